// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared states and widths for the mux_4 scan sequencer
package mux_scan_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam int NUM_CH = 4;
   localparam int CH_W = 2;
   localparam int CNT_W = 4;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: control, status and mux-select bundle of the scan sequencer
interface mux_scan_ctrl_if;
   import mux_scan_pkg::*;
   logic start;
   logic cont_en;
   logic abort;
   logic y;
   logic c1;
   logic c2;
   logic busy;
   logic [NUM_CH-1:0] samples;
   logic scan_valid;
   modport master (
      output start, cont_en, abort, y,
      input c1, c2, busy, samples, scan_valid
   );
   modport slave (
      input start, cont_en, abort, y,
      output c1, c2, busy, samples, scan_valid
   );
endinterface

// File: rtl/mux_4.sv
// mux_4: combinational 4:1 data mux, channel {c1,c2}=00 selects x1
module mux_4 (
   input  logic x1,
   input  logic x2,
   input  logic x3,
   input  logic x4,
   input  logic c1,
   input  logic c2,
   output logic y
);
   assign y = c1 ? (c2 ? x4 : x3) : (c2 ? x2 : x1);
endmodule

// File: rtl/scan_settle_timer.sv
// scan_settle_timer: loadable countdown that stops at zero and flags it
module scan_settle_timer
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks mux_4 through channels 0..3, samples y after a settle
// time and publishes the four captured bits with a one-cycle valid
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input logic            clk,
   input logic            rst_n,
   mux_scan_ctrl_if.slave bus
);
   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("mux_scan_ctrl: SETTLE_CYC=%0d outside 1..15", SETTLE_CYC);
   end
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   state_t state_q, state_d;
   logic [CH_W-1:0] ch_q, ch_d, sel_q, sel_d;
   logic [NUM_CH-1:0] shadow_q, shadow_d, samples_q, samples_d;
   logic load, en, zero;
   scan_settle_timer u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .load_val_i(RELOAD),
      .en_i      (en),
      .zero_o    (zero)
   );
   always_comb begin
      state_d = state_q;
      ch_d = ch_q;
      shadow_d = shadow_q;
      samples_d = samples_q;
      load = 1'b0;
      en = 1'b0;
      case (state_q)
         IDLE: if (bus.start && !bus.abort) begin
            state_d = SETTLE;
            ch_d = '0;
            load = 1'b1;
         end
         SETTLE: if (zero) state_d = SAMPLE;
         else en = 1'b1;
         SAMPLE: begin
            shadow_d[ch_q] = bus.y;
            if (ch_q == LAST_CH) begin
               state_d = DONE;
               samples_d = shadow_d;
            end else begin
               state_d = SETTLE;
               ch_d = ch_q + 1'b1;
               load = 1'b1;
            end
         end
         DONE: if (bus.cont_en) begin
            state_d = SETTLE;
            ch_d = '0;
            load = 1'b1;
         end else state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort drops the scan in flight; a DONE already published stays published
      if (bus.abort && state_q != IDLE) begin
         state_d = IDLE;
         ch_d = '0;
         shadow_d = '0;
         samples_d = samples_q;
         load = 1'b0;
      end
      sel_d = (state_d == SETTLE || state_d == SAMPLE) ? ch_d : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         ch_q <= '0;
         sel_q <= '0;
         shadow_q <= '0;
         samples_q <= '0;
      end else begin
         state_q <= state_d;
         ch_q <= ch_d;
         sel_q <= sel_d;
         shadow_q <= shadow_d;
         samples_q <= samples_d;
      end
   assign bus.c1 = sel_q[1];
   assign bus.c2 = sel_q[0];
   assign bus.busy = state_q != IDLE;
   assign bus.scan_valid = state_q == DONE;
   assign bus.samples = samples_q;
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 4:1 data-flow mux (mux_4). It drives the mux select lines c1/c2 and walks through channels 0..3. After each select change it waits a programmable settle time, then captures the mux output y. When a scan completes, it presents the four captured bits as one vector with a valid pulse. It turns the combinational mux into a time-multiplexed 4-channel sampler, in single-shot or continuous mode.

Parameters:
SETTLE_CYC, 2, clock cycles the select is held before y is sampled; legal range 1..15.

Ports:
clk  in  1  system clock; all state is updated on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
cont_en  in  1  1 = restart a new scan automatically after DONE; sampled in DONE.
abort  in  1  synchronous abort; returns to IDLE.
y  in  1  output of mux_4; same clock domain.
c1  out  1  select MSB to mux_4.
c2  out  1  select LSB to mux_4. Channel n = {c1,c2}, so 00 selects x1 and 11 selects x4.
busy  out  1  high in every state except IDLE.
samples  out  4  last completed scan; bit n = y captured while channel n was selected.
scan_valid  out  1  one-cycle pulse when samples updates.

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE; c1=c2=0; busy=0; samples=4'b0000; scan_valid=0.
  - Shadow register and both counters cleared.
  - A scan in progress is discarded.
- State machine (package enum): IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - {c1,c2}=00.
  - start=1 -> SETTLE with channel=0 and settle count loaded with SETTLE_CYC-1.
- SETTLE:
  - {c1,c2} driven from the channel register (registered outputs, glitch-free).
  - Holds for exactly SETTLE_CYC cycles, decrementing the count.
  - Count==0 -> SAMPLE.
- SAMPLE (1 cycle):
  - shadow[channel] <= y at the closing edge.
  - channel<3 -> channel+1, reload the count, go to SETTLE.
  - channel==3 -> DONE.
- DONE (1 cycle):
  - samples <= shadow; scan_valid=1 for this cycle only.
  - cont_en=1 -> SETTLE with channel=0; busy stays high and no IDLE cycle is inserted.
  - Otherwise -> IDLE.
- Latency: scan_valid is high in cycle 4*(SETTLE_CYC+1)+1 after the edge that accepts start. For SETTLE_CYC=2 that is cycle 13.
- Channel counter: 2 bits; the 3->0 wrap happens only via DONE.
- start outside IDLE is ignored; it is not queued.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and {c1,c2}=00.
  - samples is unchanged and scan_valid is not asserted.
  - Shadow register is cleared.
- abort and start in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- abort in DONE: the samples update and scan_valid for that cycle still occur, and the next state is IDLE even if cont_en=1.
- If reset is released mid-cycle, the FSM resumes from IDLE on the first rising edge.
- Settle counter is 4 bits wide. SETTLE_CYC values outside 1..15 are illegal; the block reports this with an elaboration-time error.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - constant NUM_CH=4;
  - constant CH_W=2;
  - constant CNT_W=4.
- One sub-module: scan_settle_timer.
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Implements the SETTLE countdown; the FSM, channel counter and shadow register stay in mux_scan_ctrl.
- Top-level bench instantiates mux_scan_ctrl together with mux_4, with c1/c2/y connected between them.

Test Plan:
- Reset check: hold rst_n=0 and toggle start -> c1=c2=0, busy=0, samples=0000, scan_valid=0. Assert rst_n asynchronously mid-SETTLE -> all outputs clear immediately, with no clock edge required.
- Single scan: x1..x4=0,1,0,1, SETTLE_CYC=2, one start pulse -> {c1,c2} steps 00,01,10,11 with 3 cycles each. scan_valid pulses in cycle 13, samples=4'b1010, then busy=0.
- Continuous mode: cont_en=1 with x=1,1,0,0 -> samples=4'b0011 and scan_valid every 13 cycles. Change x to 0,0,1,1 mid-run -> the next complete scan reports 4'b1100.
- Abort: abort=1 during channel 2 SETTLE -> IDLE next cycle, samples keeps its previous value, no scan_valid. Then start with abort=1 in the same cycle -> remains IDLE.
- Ignored start: pulse start again at cycle 5 of a scan -> exactly one scan_valid, with no extra scan queued.
- SETTLE_CYC=1: x=1,0,0,1 -> each channel lasts 2 cycles, scan_valid in cycle 9, samples=4'b1001.
